ifetch_unit: RTL and testbench

Instruction fetch stage that generates the PC, issues in-order requests to instruction memory, and buffers returned instructions. Presents {inst_addr_o, inst_o, inst_valid} to the downstream IF/ID pipeline register. Supports a stall (hold_en) and redirect (jump_en) from the control unit. Redirect squashes in-flight fetches so stale instructions never reach decode.

---
 rtl/ifetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order requests to instruction
// memory, tracks in-flight fetch addresses and buffers returned instructions for
// the IF/ID register. A redirect flushes the buffer and discards every response
// still in flight so that stale instructions never reach decode.
module ifetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rstn,
  // Control unit
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  hold_en,
  // Instruction memory request channel
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  // Instruction memory response channel (in order, no backpressure)
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  // IF/ID
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_pc;

  // Addresses of requests accepted by memory but not yet answered.
  logic [ADDR_WIDTH-1:0] r_aq_addr [2];
  logic                  r_aq_wptr;
  logic                  r_aq_rptr;

  // Returned instructions waiting for decode.
  logic [ADDR_WIDTH-1:0] r_buf_addr [2];
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic                  r_buf_wptr;
  logic                  r_buf_rptr;
  logic [1:0]            r_buf_cnt;

  logic [1:0]            r_outstanding;
  // Responses still owed for requests issued before the latest redirect.
  logic [1:0]            r_drop_cnt;
  // Address shown on inst_addr_o while the buffer is empty.
  logic [ADDR_WIDTH-1:0] r_last_addr;

  // ---------------------------------------------------------------------------
  // Next-state / decode wires
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_jump_target;
  logic                  w_buf_nonempty;
  logic                  w_pop;
  logic [2:0]            w_occ_after_pop;
  logic                  w_credit;
  logic                  w_req_fire;
  logic                  w_rsp;
  logic                  w_rsp_keep;
  logic                  w_rsp_drop;
  logic                  w_buf_push;
  logic                  w_buf_pop;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ADDR_WIDTH-1:0] w_inst_addr;

  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [1:0]            w_outstanding_d;
  logic [1:0]            w_drop_cnt_d;
  logic [1:0]            w_buf_cnt_d;
  logic                  w_buf_wptr_d;
  logic                  w_buf_rptr_d;

  // Handshake, credit and response classification.
  always_comb begin
    // Masking keeps every bit of jump_addr in use while forcing word alignment.
    w_jump_target   = jump_addr & ~ADDR_WIDTH'(3);
    w_buf_nonempty  = (r_buf_cnt != 2'd0);
    w_pop           = rstn & w_buf_nonempty & ~hold_en;
    // Buffer slots plus in-flight requests, counting the slot freed this cycle.
    w_occ_after_pop = 3'(r_buf_cnt) + 3'(r_outstanding) - 3'(w_pop);
    w_credit        = (w_occ_after_pop < 3'd2);
    w_req_fire      = imem_req_valid & imem_req_ready;
    w_rsp           = rstn & imem_rsp_valid;
    // A response in the redirect cycle belongs to the old stream.
    w_rsp_keep      = w_rsp & ~jump_en & (r_drop_cnt == 2'd0);
    w_rsp_drop      = w_rsp & ~w_rsp_keep;
    w_buf_push      = w_rsp_keep;
    w_buf_pop       = w_pop & ~jump_en;
  end

  // Buffer head selection and the address shown while empty.
  always_comb begin
    w_head_addr = r_buf_addr[r_buf_rptr];
    w_head_data = r_buf_data[r_buf_rptr];
    w_inst_addr = w_buf_nonempty ? w_head_addr : r_last_addr;
  end

  // Next PC, outstanding count and drop count.
  always_comb begin
    w_pc_d          = r_pc;
    w_outstanding_d = r_outstanding + 2'(w_req_fire) - 2'(w_rsp);
    w_drop_cnt_d    = r_drop_cnt;
    if (jump_en) begin
      w_pc_d       = w_jump_target;
      // Everything still in flight is stale; a response landing now is already gone.
      w_drop_cnt_d = r_outstanding - 2'(w_rsp);
    end else begin
      if (w_req_fire) begin
        w_pc_d = r_pc + ADDR_WIDTH'(4);
      end
      if (w_rsp_drop) begin
        w_drop_cnt_d = r_drop_cnt - 2'd1;
      end
    end
  end

  // Instruction buffer occupancy and pointers; a redirect empties it.
  always_comb begin
    w_buf_cnt_d  = r_buf_cnt + 2'(w_buf_push) - 2'(w_buf_pop);
    w_buf_wptr_d = r_buf_wptr ^ w_buf_push;
    w_buf_rptr_d = r_buf_rptr ^ w_buf_pop;
    if (jump_en) begin
      w_buf_cnt_d  = 2'd0;
      w_buf_wptr_d = 1'b0;
      w_buf_rptr_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc          <= RESET_PC;
      r_aq_wptr     <= 1'b0;
      r_aq_rptr     <= 1'b0;
      r_buf_wptr    <= 1'b0;
      r_buf_rptr    <= 1'b0;
      r_buf_cnt     <= 2'd0;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_last_addr   <= '0;
    end else begin
      r_pc          <= w_pc_d;
      // The address queue is not flushed on redirect: dropped responses still pop it.
      r_aq_wptr     <= r_aq_wptr ^ w_req_fire;
      r_aq_rptr     <= r_aq_rptr ^ w_rsp;
      r_buf_wptr    <= w_buf_wptr_d;
      r_buf_rptr    <= w_buf_rptr_d;
      r_buf_cnt     <= w_buf_cnt_d;
      r_outstanding <= w_outstanding_d;
      r_drop_cnt    <= w_drop_cnt_d;
      r_last_addr   <= w_inst_addr;
    end
  end

  // Address queue storage; contents are only meaningful between its pointers.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_aq_addr[r_aq_wptr] <= r_pc;
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk) begin
    if (w_buf_push) begin
      r_buf_addr[r_buf_wptr] <= r_aq_addr[r_aq_rptr];
      r_buf_data[r_buf_wptr] <= imem_rsp_data;
    end
  end

  // Protocol checks: the credit rule makes both of these unreachable.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(w_rsp_keep && r_buf_cnt == 2'd2))
        else $error("ifetch_unit: response arrived with instruction buffer full");
      assert (!(w_rsp && r_outstanding == 2'd0))
        else $error("ifetch_unit: response arrived with nothing outstanding");
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // Request and IF/ID outputs, forced idle while reset is asserted.
  always_comb begin
    imem_req_valid = rstn & ~jump_en & w_credit;
    imem_addr      = r_pc;
    inst_valid     = rstn & w_buf_nonempty;
    inst_o         = inst_valid ? w_head_data : NOP_INSTR;
    inst_addr_o    = rstn ? w_inst_addr : '0;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A scoreboard queue receives the address
// the bench expects for each accepted fetch; entries are popped when decode
// consumes an instruction. Redirects and resets discard the expected entries.
module tb_ifetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  // Second instance exercising a non-zero reset PC that wraps.
  logic        w2_req_valid;
  logic [31:0] w2_addr;
  logic        w2_rsp_valid;
  logic [31:0] w2_rsp_data;
  logic        w2_inst_valid;
  logic [31:0] w2_inst;
  logic [31:0] w2_inst_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;
  int n_consumed = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] sb [$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq [$];

  always #5 clk = ~clk;

  ifetch_unit u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .hold_en        (hold_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o)
  );

  ifetch_unit #(
    .RESET_PC (WRAP_PC)
  ) u_wrap (
    .clk            (clk),
    .rstn           (rstn),
    .jump_en        (1'b0),
    .jump_addr      (32'h0),
    .hold_en        (1'b0),
    .imem_req_valid (w2_req_valid),
    .imem_req_ready (1'b1),
    .imem_addr      (w2_addr),
    .imem_rsp_valid (w2_rsp_valid),
    .imem_rsp_data  (w2_rsp_data),
    .inst_valid     (w2_inst_valid),
    .inst_o         (w2_inst),
    .inst_addr_o    (w2_inst_addr)
  );

  // One-cycle memory for the wrap instance; data equals address.
  always @(posedge clk) begin
    w2_rsp_valid <= rstn & w2_req_valid;
    w2_rsp_data  <= w2_addr;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Bounded wait for the next valid instruction, then check its address.
  task automatic wait_valid(input string tag, input logic [31:0] exp, input int budget);
    logic [31:0] seen;
    seen = 32'd0;
    for (int i = 0; i < budget && seen == 32'd0; i++) begin
      sample();
      if (inst_valid) seen = 32'd1;
    end
    check({tag, "_seen"}, seen, 32'd1);
    if (seen == 32'd1) check(tag, inst_addr_o, exp);
  endtask

  // Redirect for one cycle; the scoreboard drops everything already expected.
  task automatic do_jump(input logic [31:0] target);
    tick();
    jump_en   = 1'b1;
    jump_addr = target;
    sb.delete();
    exp_pc    = target & ~32'd3;
    sample();
    check("req_in_jump", {31'd0, imem_req_valid}, 32'd0);
    tick();
    jump_en = 1'b0;
    sample();
    check("valid_after_jump", {31'd0, inst_valid}, 32'd0);
  endtask

  // Cycle counter for the memory model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // In-order memory with programmable latency, one response per cycle.
  initial begin
    int due;
    int last_due;
    mreq_t m;
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mq.delete();
        last_due       = 0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_data(mq[0].addr);
          void'(mq.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          due = cyc + 1 + mem_lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          m.addr   = imem_addr;
          m.due    = due;
          mq.push_back(m);
        end
      end
    end
  end

  // Monitor: request addresses, scoreboard pops, hold stability, reset outputs.
  initial begin
    logic        prev_hold;
    logic        prev_valid;
    logic        prev_rstn;
    logic        prev_jump;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic [31:0] ea;
    prev_hold  = 1'b0;
    prev_valid = 1'b0;
    prev_rstn  = 1'b0;
    prev_jump  = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_o", inst_o, NOP);
        check("rst_inst_addr", inst_addr_o, 32'd0);
      end else begin
        if (jump_en) check("mon_req_in_jump", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid) check("imem_addr", imem_addr, exp_pc);
        if (imem_req_valid && imem_req_ready) begin
          sb.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
        if (hold_en && prev_hold && prev_valid && prev_rstn && !prev_jump) begin
          check("hold_valid", {31'd0, inst_valid}, 32'd1);
          check("hold_addr", inst_addr_o, prev_addr);
          check("hold_data", inst_o, prev_data);
        end
        if (inst_valid && !hold_en && !jump_en) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            ea = sb.pop_front();
            check("inst_addr", inst_addr_o, ea);
            check("inst_data", inst_o, mem_data(ea));
            n_consumed++;
            last_addr = ea;
          end
        end
      end
      prev_hold  = hold_en;
      prev_valid = inst_valid;
      prev_rstn  = rstn;
      prev_jump  = jump_en;
      prev_addr  = inst_addr_o;
      prev_data  = inst_o;
    end
  end

  // Directed sequence.
  initial begin
    int n0;
    rstn           = 1'b0;
    jump_en        = 1'b0;
    jump_addr      = '0;
    hold_en        = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) tick();

    // Reset release: request in cycle 1, first instruction in cycle 3.
    rstn = 1'b1;
    sample();
    check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("c1_addr", imem_addr, 32'd0);
    check("c1_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("wrap_c1", w2_addr, 32'hFFFF_FFF8);
    sample();
    check("c2_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("wrap_c2", w2_addr, 32'hFFFF_FFFC);
    sample();
    check("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("c3_inst_addr", inst_addr_o, 32'd0);
    check("wrap_c3", w2_addr, 32'h0000_0000);
    check("wrap_c3_valid", {31'd0, w2_inst_valid}, 32'd1);
    check("wrap_c3_iaddr", w2_inst_addr, WRAP_PC);
    check("wrap_c3_inst", w2_inst, WRAP_PC);

    // Sustained one instruction per cycle.
    n0 = n_consumed;
    repeat (20) sample();
    check("throughput", 32'(n_consumed - n0), 32'd20);

    // Stall for five cycles.
    tick();
    hold_en = 1'b1;
    repeat (5) sample();
    check("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("hold_occupancy", 32'(sb.size()), 32'd2);
    tick();
    hold_en = 1'b0;
    repeat (10) sample();

    // Memory not ready for three cycles: buffer drains, address held.
    tick();
    imem_req_ready = 1'b0;
    repeat (3) sample();
    check("nrdy_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("nrdy_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("nrdy_inst_o", inst_o, NOP);
    check("nrdy_last_addr", inst_addr_o, last_addr);
    tick();
    imem_req_ready = 1'b1;
    repeat (8) sample();

    // Redirect with 1-cycle memory; target fetched the cycle after.
    do_jump(32'h0000_0100);
    check("jump_first_req", {31'd0, imem_req_valid}, 32'd1);
    check("jump_first_addr", imem_addr, 32'h0000_0100);
    wait_valid("jump100", 32'h0000_0100, 10);
    repeat (4) sample();

    // Build two outstanding requests with 3-cycle memory, then redirect.
    tick();
    mem_lat = 3;
    do_jump(32'h0000_0500);
    tick();
    sample();
    do_jump(32'h0000_0102);
    wait_valid("jump102", 32'h0000_0100, 20);
    repeat (6) sample();

    // Back-to-back redirects: the second target wins.
    tick();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0200;
    sb.delete();
    exp_pc    = 32'h0000_0200;
    sample();
    tick();
    jump_addr = 32'h0000_0300;
    sb.delete();
    exp_pc    = 32'h0000_0300;
    sample();
    tick();
    jump_en = 1'b0;
    sample();
    check("b2b_inst_valid", {31'd0, inst_valid}, 32'd0);
    wait_valid("jump300", 32'h0000_0300, 20);
    repeat (6) sample();

    // PC wrap through the top of the address space.
    tick();
    mem_lat = 1;
    do_jump(32'hFFFF_FFF8);
    wait_valid("jump_wrap", 32'hFFFF_FFF8, 10);
    repeat (6) sample();

    // Reset mid-stream with a full buffer.
    tick();
    hold_en = 1'b1;
    repeat (4) sample();
    check("full_valid", {31'd0, inst_valid}, 32'd1);
    check("full_occupancy", 32'(sb.size()), 32'd2);
    tick();
    rstn    = 1'b0;
    hold_en = 1'b0;
    sb.delete();
    exp_pc  = 32'd0;
    sample();
    check("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    sample();
    check("mrst_refetch_req", {31'd0, imem_req_valid}, 32'd1);
    check("mrst_refetch_addr", imem_addr, 32'd0);
    wait_valid("mrst_first", 32'd0, 10);
    repeat (5) sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
